// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the dispatch controller: FSM state encoding and
// queue-select decoding.
package dispatch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        REDIR   = 2'd2
    } disp_state_e;

    // Widest queue select the decoder supports; callers truncate to their queue count.
    localparam int unsigned MAX_QSEL_WIDTH = 4;
    localparam int unsigned MAX_QUEUES     = 2 ** MAX_QSEL_WIDTH;

    function automatic logic [MAX_QUEUES-1:0] qsel_onehot(input logic [MAX_QSEL_WIDTH-1:0] qsel);
        logic [MAX_QUEUES-1:0] oh;
        oh       = '0;
        oh[qsel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tag_free_list.sv
// Circular free list of destination tags. Starts full with tags popped in
// ascending order; returned tags are appended and become poppable next cycle.
module tag_free_list #(
    parameter int unsigned TAG_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pop,
    input  logic                 push,
    input  logic [TAG_WIDTH-1:0] push_tag,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned NUM_TAGS = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] FULL_COUNT = (TAG_WIDTH + 1)'(NUM_TAGS);

    logic [TAG_WIDTH-1:0] mem_q [NUM_TAGS];
    logic [TAG_WIDTH-1:0] rd_ptr_q;
    logic [TAG_WIDTH-1:0] wr_ptr_q;
    logic [TAG_WIDTH:0]   count_q;
    logic [TAG_WIDTH:0]   count_d;
    logic                 overflow_q;
    logic                 do_pop;
    logic                 do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & ~full;
    assign tag_out = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                mem_q[i] <= TAG_WIDTH'(i);
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= FULL_COUNT;
            empty      <= 1'b0;
            full       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_tag;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty   <= (count_d == '0);
            full    <= (count_d == FULL_COUNT);
            // Sticky: a return into a full list means a tag was duplicated upstream.
            overflow_q <= overflow_q | (push & full);
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Tomasulo dispatch controller: allocates tags, routes instructions to issue queues,
// and holds dispatch across unresolved branches. Optional DISPATCH_PERF_CNT_EN adds stall_cycles.
module dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 4,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned QSEL_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [QSEL_WIDTH-1:0] in_qsel,
    input  logic                  in_regwrite,
    input  logic                  in_branch,
    input  logic [4:0]            in_rd,
    input  logic [NUM_QUEUES-1:0] iq_full,
    output logic [NUM_QUEUES-1:0] disp_en,
    output logic [TAG_WIDTH-1:0]  disp_rd_tag,
    output logic                  rst_we,
    output logic [4:0]            rst_rd,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic                  cdb_branch,
    input  logic                  cdb_branch_taken,
    output logic                  redirect
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    disp_state_e          state_q;
    logic                 accept;
    logic                 fl_pop;
    logic                 fl_push;
    logic                 fl_empty;
    logic                 fl_full;
    logic [TAG_WIDTH-1:0] fl_tag;

    assign in_ready = (state_q == RUN) & ~iq_full[in_qsel] & ~(in_regwrite & fl_empty);
    assign accept   = in_valid & in_ready;
    assign fl_pop   = accept & in_regwrite;
    assign fl_push  = cdb_valid & ~cdb_branch;

    tag_free_list #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_free_list (
        .clk      (clk),
        .reset    (reset),
        .pop      (fl_pop),
        .push     (fl_push),
        .push_tag (cdb_tag),
        .tag_out  (fl_tag),
        .empty    (fl_empty),
        .full     (fl_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            disp_en     <= '0;
            disp_rd_tag <= '0;
            rst_we      <= 1'b0;
            rst_rd      <= '0;
            redirect    <= 1'b0;
        end else begin
            disp_en  <= accept ? NUM_QUEUES'(qsel_onehot(MAX_QSEL_WIDTH'(in_qsel))) : '0;
            rst_we   <= fl_pop;
            redirect <= 1'b0;
            if (fl_pop) begin
                disp_rd_tag <= fl_tag;
                rst_rd      <= in_rd;
            end
            unique case (state_q)
                RUN: begin
                    if (accept & in_branch) begin
                        state_q <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (cdb_valid & cdb_branch) begin
                        if (cdb_branch_taken) begin
                            state_q  <= REDIR;
                            redirect <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                REDIR: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (in_valid & ~in_ready & ~&stall_cycles) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    // Only outstanding tags come back on the CDB, so a return can never meet a full list.
    no_return_when_full: assert property (@(posedge clk) disable iff (reset)
        fl_push |-> !fl_full);

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Randomised bench for dispatch_ctrl against a queue-based reference model, plus
// directed scenarios for tag allocation, exhaustion, branch handling and reset.
module tb_dispatch_ctrl;

    localparam int NQ = 4;
    localparam int TW = 6;
    localparam int QW = 2;
    localparam int NT = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [QW-1:0] in_qsel;
    logic          in_regwrite;
    logic          in_branch;
    logic [4:0]    in_rd;
    logic [NQ-1:0] iq_full;
    logic [NQ-1:0] disp_en;
    logic [TW-1:0] disp_rd_tag;
    logic          rst_we;
    logic [4:0]    rst_rd;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic          cdb_branch;
    logic          cdb_branch_taken;
    logic          redirect;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    dispatch_ctrl #(
        .NUM_QUEUES (NQ),
        .TAG_WIDTH  (TW),
        .QSEL_WIDTH (QW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_qsel          (in_qsel),
        .in_regwrite      (in_regwrite),
        .in_branch        (in_branch),
        .in_rd            (in_rd),
        .iq_full          (iq_full),
        .disp_en          (disp_en),
        .disp_rd_tag      (disp_rd_tag),
        .rst_we           (rst_we),
        .rst_rd           (rst_rd),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_branch       (cdb_branch),
        .cdb_branch_taken (cdb_branch_taken),
        .redirect         (redirect)
`ifdef DISPATCH_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: free tags as an ordered queue, branch state as plain flags.
    int         free_q[$];
    int         outst[$];
    bit         m_wait;
    bit         m_redir;
    logic [3:0] e_en;
    int         e_tag;
    bit         e_we;
    int         e_rd;
    longint     e_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q = {};
        for (int i = 0; i < NT; i++) free_q.push_back(i);
        outst   = {};
        m_wait  = 1'b0;
        m_redir = 1'b0;
        e_en    = '0;
        e_tag   = 0;
        e_we    = 1'b0;
        e_rd    = 0;
        e_stall = 0;
    endtask

    task automatic set_idle();
        in_valid         = 1'b0;
        in_qsel          = '0;
        in_regwrite      = 1'b0;
        in_branch        = 1'b0;
        in_rd            = '0;
        iq_full          = '0;
        cdb_valid        = 1'b0;
        cdb_tag          = '0;
        cdb_branch       = 1'b0;
        cdb_branch_taken = 1'b0;
    endtask

    function automatic bit model_ready();
        return !m_wait && !m_redir && !iq_full[in_qsel] && !(in_regwrite && free_q.size() == 0);
    endfunction

    // One clock: check in_ready, advance model at the edge, check registered outputs.
    task automatic tick();
        bit rdy;
        bit acc;
        bit was_full;
        #1;
        rdy      = model_ready();
        check("in_ready", in_ready, rdy);
        acc      = in_valid && rdy;
        was_full = (free_q.size() == NT);
        @(posedge clk);
        #1;
        e_en = acc ? (4'b0001 << in_qsel) : 4'b0000;
        e_we = acc && in_regwrite;
        if (e_we) begin
            e_tag = free_q.pop_front();
            e_rd  = in_rd;
            outst.push_back(e_tag);
        end
        if (cdb_valid && !cdb_branch && !was_full) free_q.push_back(cdb_tag);
        if (in_valid && !rdy) e_stall++;
        if (m_redir) begin
            m_redir = 1'b0;
        end else if (m_wait) begin
            if (cdb_valid && cdb_branch) begin
                m_wait  = 1'b0;
                m_redir = cdb_branch_taken;
            end
        end else if (acc && in_branch) begin
            m_wait = 1'b1;
        end
        check("disp_en", disp_en, e_en);
        check("disp_rd_tag", disp_rd_tag, e_tag);
        check("rst_we", rst_we, e_we);
        if (e_we) check("rst_rd", rst_rd, e_rd);
        check("redirect", redirect, m_redir);
`ifdef DISPATCH_PERF_CNT_EN
        check("stall_cycles", stall_cycles, e_stall);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_disp_en", disp_en, 0);
        check("rst_disp_rd_tag", disp_rd_tag, 0);
        check("rst_rst_we", rst_we, 0);
        check("rst_rst_rd", rst_rd, 0);
        check("rst_redirect", redirect, 0);
`ifdef DISPATCH_PERF_CNT_EN
        check("rst_stall_cycles", stall_cycles, 0);
`endif
        @(negedge clk);
        set_idle();
        reset = 1'b0;
    endtask

    task automatic drop_outst(input int tag);
        foreach (outst[i]) begin
            if (outst[i] == tag) begin
                outst.delete(i);
                return;
            end
        end
    endtask

    task automatic accept_regwrite(input int qsel, input int rd);
        set_idle();
        in_valid    = 1'b1;
        in_regwrite = 1'b1;
        in_qsel     = QW'(qsel);
        in_rd       = 5'(rd);
        tick();
    endtask

    initial begin
        set_idle();
        do_reset();

        // Tags come out in ascending order after reset.
        for (int i = 0; i < 3; i++) begin
            accept_regwrite(0, i + 1);
            check("t1_tag", disp_rd_tag, i);
            check("t1_en", disp_en, 4'b0001);
            check("t1_we", rst_we, 1);
        end

        // Exhaust the list, then return tag 5 and watch it reallocated.
        for (int i = 3; i < NT; i++) accept_regwrite(i % NQ, i % 32);
        #1;
        check("t2_ready_empty", in_ready, 0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        drop_outst(5);
        tick();
        cdb_valid = 1'b0;
        tick();
        check("t2_tag5", disp_rd_tag, 5);

        // Taken branch: block, one-cycle redirect, then ready again.
        for (int taken = 1; taken >= 0; taken--) begin
            set_idle();
            in_valid  = 1'b1;
            in_branch = 1'b1;
            tick();
            in_branch = 1'b0;
            tick();
            check("t34_ready_wait", in_ready, 0);
            cdb_valid        = 1'b1;
            cdb_branch       = 1'b1;
            cdb_branch_taken = taken[0];
            tick();
            check("t34_redirect", redirect, taken[0]);
            set_idle();
            in_valid = 1'b1;
            if (taken != 0) begin
                tick();
                check("t3_redirect_drop", redirect, 0);
            end
            #1;
            check("t34_ready_after", in_ready, 1);
            tick();
        end

        // Full queue blocks its own traffic only.
        set_idle();
        in_valid = 1'b1;
        iq_full  = 4'b0100;
        in_qsel  = 2'd2;
        #1;
        check("t5_ready_full", in_ready, 0);
        tick();
        in_qsel = 2'd1;
        tick();
        check("t5_en", disp_en, 4'b0010);

        // Reset during a branch wait with tags outstanding.
        do_reset();
        for (int i = 0; i < 10; i++) accept_regwrite(i % NQ, i);
        set_idle();
        in_valid  = 1'b1;
        in_branch = 1'b1;
        tick();
        in_branch = 1'b0;
        tick();
        do_reset();
        accept_regwrite(3, 7);
        check("t6_tag0", disp_rd_tag, 0);

        // Randomised traffic with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            set_idle();
            in_valid    = ($urandom_range(0, 3) != 0);
            in_qsel     = QW'($urandom_range(0, NQ - 1));
            in_regwrite = ($urandom_range(0, 9) < 7);
            in_branch   = ($urandom_range(0, 9) == 0);
            in_rd       = 5'($urandom_range(0, 31));
            for (int q = 0; q < NQ; q++) iq_full[q] = ($urandom_range(0, 4) == 0);
            if (m_wait && $urandom_range(0, 2) == 0) begin
                cdb_valid        = 1'b1;
                cdb_branch       = 1'b1;
                cdb_branch_taken = $urandom_range(0, 1) != 0;
            end else if (!m_wait && $urandom_range(0, 19) == 0) begin
                cdb_valid        = 1'b1;
                cdb_branch       = 1'b1;
                cdb_branch_taken = $urandom_range(0, 1) != 0;
            end else if (outst.size() > 0 && $urandom_range(0, 4) < 2) begin
                int idx;
                idx       = $urandom_range(0, outst.size() - 1);
                cdb_valid = 1'b1;
                cdb_tag   = TW'(outst[idx]);
                outst.delete(idx);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
